// File: rtl/adder_error_monitor.sv
// adder_error_monitor: per-campaign error statistics (count, error count, sum/max ED) for exact vs approximate sums.
// Optional ADDER_ERR_MON_SQ_EN adds the sum-of-squared-ED accumulator and its sum_sq_ed port.
`default_nettype none

module adder_error_monitor #(
  parameter int W         = 9,
  parameter int N_SAMPLES = 65536,
  parameter int CNT_W     = 17
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           sum_exact,
  input  logic [W-1:0]           sum_approx,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       sample_cnt,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [CNT_W+W-1:0]     sum_ed,
  output logic [W-1:0]           max_ed
`ifdef ADDER_ERR_MON_SQ_EN
  ,
  output logic [CNT_W+2*W-1:0]   sum_sq_ed
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [CNT_W-1:0] N_LIM = CNT_W'(N_SAMPLES);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] acc_cnt, acc_nxt;
  logic             xfer, clr, ready_nxt;
  logic             v1, v2;
  logic [W-1:0]     ed1;
  logic             ne1;
  logic signed [W:0] diff_c;
  logic [W-1:0]     ed_c;

  assign xfer = in_valid & in_ready;
  assign clr  = (state == S_IDLE) & start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; DRAIN waits for both the ED stage and the stats stage to empty
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (acc_cnt == N_LIM) state_nxt = S_DRAIN;
      S_DRAIN: if (!v1 && !v2) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state != S_IDLE);
    acc_nxt   = clr ? '0 : (xfer ? acc_cnt + CNT_W'(1) : acc_cnt);
    ready_nxt = (state_nxt == S_RUN) && (acc_nxt < N_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt  <= '0;
      in_ready <= 1'b0;
      done     <= 1'b0;
    end else begin
      acc_cnt  <= acc_nxt;
      in_ready <= ready_nxt;
      if (clr)
        done <= 1'b0;
      else if (state == S_DRAIN && state_nxt == S_IDLE)
        done <= 1'b1;
    end
  end

  assign diff_c = $signed({1'b0, sum_exact}) - $signed({1'b0, sum_approx});
  assign ed_c   = W'(diff_c[W] ? -diff_c : diff_c);

`ifdef ADDER_ERR_MON_SQ_EN
  logic [2*W-1:0] sq_c, sq1;
  assign sq_c = {{W{1'b0}}, ed_c} * {{W{1'b0}}, ed_c};
`endif

  // Stage 1: error distance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      ed1 <= '0;
      ne1 <= 1'b0;
`ifdef ADDER_ERR_MON_SQ_EN
      sq1 <= '0;
`endif
    end else begin
      v1  <= xfer;
      ed1 <= ed_c;
      ne1 <= (ed_c != '0);
`ifdef ADDER_ERR_MON_SQ_EN
      sq1 <= sq_c;
`endif
    end
  end

  // Stage 2: accumulation; widths cover the worst case so no saturation is needed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2         <= 1'b0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
      max_ed     <= '0;
`ifdef ADDER_ERR_MON_SQ_EN
      sum_sq_ed  <= '0;
`endif
    end else begin
      v2 <= v1;
      if (clr) begin
        sample_cnt <= '0;
        err_cnt    <= '0;
        sum_ed     <= '0;
        max_ed     <= '0;
`ifdef ADDER_ERR_MON_SQ_EN
        sum_sq_ed  <= '0;
`endif
      end else if (v1) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
        err_cnt    <= err_cnt + CNT_W'(ne1);
        sum_ed     <= sum_ed + (CNT_W+W)'(ed1);
        if (ed1 > max_ed) max_ed <= ed1;
`ifdef ADDER_ERR_MON_SQ_EN
        sum_sq_ed  <= sum_sq_ed + (CNT_W+2*W)'(sq1);
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_error_monitor.sv
// Directed bench for adder_error_monitor (N_SAMPLES=4 instance plus an N_SAMPLES=3 instance).
`default_nettype none

module tb_adder_error_monitor;

  localparam int W = 9;
  localparam int CNT_W = 17;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, start3, in_valid3;
  logic [W-1:0] sum_exact, sum_approx, s3;
  logic in_ready, busy, done, in_ready3, busy3, done3;
  logic [CNT_W-1:0] sample_cnt, err_cnt, sample_cnt3, err_cnt3;
  logic [CNT_W+W-1:0] sum_ed, sum_ed3;
  logic [W-1:0] max_ed, max_ed3;
`ifdef ADDER_ERR_MON_SQ_EN
  logic [CNT_W+2*W-1:0] sum_sq_ed, sum_sq_ed3;
`endif

  int checks = 0;
  int errors = 0;
  int cyc;

  always #5 clk = ~clk;

  adder_error_monitor #(.W(W), .N_SAMPLES(4), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .sum_exact(sum_exact), .sum_approx(sum_approx), .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sum_ed(sum_ed), .max_ed(max_ed)
`ifdef ADDER_ERR_MON_SQ_EN
    , .sum_sq_ed(sum_sq_ed)
`endif
  );

  adder_error_monitor #(.W(W), .N_SAMPLES(3), .CNT_W(CNT_W)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .in_valid(in_valid3), .in_ready(in_ready3),
    .sum_exact(s3), .sum_approx(s3), .busy(busy3), .done(done3),
    .sample_cnt(sample_cnt3), .err_cnt(err_cnt3), .sum_ed(sum_ed3), .max_ed(max_ed3)
`ifdef ADDER_ERR_MON_SQ_EN
    , .sum_sq_ed(sum_sq_ed3)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] e, input logic [W-1:0] a);
    sum_exact  = e;
    sum_approx = a;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    cyc = 0;
    while (done !== 1'b1 && cyc < limit) begin
      tick();
      cyc++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; sum_exact = '0; sum_approx = '0;
    start3 = 1'b0; in_valid3 = 1'b0; s3 = '0;
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sample_cnt", 64'(sample_cnt), 64'd0);
    chk("rst_sum_ed", 64'(sum_ed), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic campaign
    pulse_start();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    send(9'd100, 9'd100);
    send(9'd300, 9'd296);
    send(9'd0, 9'd8);
    send(9'd511, 9'd511);
    chk("t1_ready_low", 64'(in_ready), 64'd0);
    tick(); tick();
    chk("t1_done_t2", 64'(done), 64'd0);
    tick();
    chk("t1_done_t3", 64'(done), 64'd1);
    chk("t1_busy_t3", 64'(busy), 64'd0);
    chk("t1_sample_cnt", 64'(sample_cnt), 64'd4);
    chk("t1_err_cnt", 64'(err_cnt), 64'd2);
    chk("t1_sum_ed", 64'(sum_ed), 64'd12);
    chk("t1_max_ed", 64'(max_ed), 64'd8);
`ifdef ADDER_ERR_MON_SQ_EN
    chk("t1_sum_sq_ed", 64'(sum_sq_ed), 64'd80);
`endif
    tick();
    chk("t1_done_held", 64'(done), 64'd1);

    // Restart clears outputs; approx > exact; mid-campaign start ignored
    pulse_start();
    chk("t2_done_clr", 64'(done), 64'd0);
    chk("t2_sample_clr", 64'(sample_cnt), 64'd0);
    chk("t2_sum_ed_clr", 64'(sum_ed), 64'd0);
    chk("t2_max_ed_clr", 64'(max_ed), 64'd0);
    chk("t2_busy", 64'(busy), 64'd1);
    send(9'd5, 9'd260);
    send(9'd260, 9'd5);
    chk("t2_max_ed", 64'(max_ed), 64'd255);
    chk("t2_sum_ed_1", 64'(sum_ed), 64'd255);
    start = 1'b1;
    send(9'd7, 9'd7);
    start = 1'b0;
    chk("t2_sum_ed_2", 64'(sum_ed), 64'd510);
    chk("t2_busy_mid", 64'(busy), 64'd1);
    send(9'd7, 9'd7);
    wait_done("t2_done", 20);
    chk("t2_sample_cnt", 64'(sample_cnt), 64'd4);
    chk("t2_err_cnt", 64'(err_cnt), 64'd2);
    chk("t2_sum_ed", 64'(sum_ed), 64'd510);
    chk("t2_max_ed_f", 64'(max_ed), 64'd255);
`ifdef ADDER_ERR_MON_SQ_EN
    chk("t2_sum_sq_ed", 64'(sum_sq_ed), 64'd130050);
`endif

    // Back-to-back valid for 10 cycles
    pulse_start();
    sum_exact = 9'd10; sum_approx = 9'd12;
    for (int k = 1; k <= 10; k++) begin
      in_valid = 1'b1;
      tick();
      chk($sformatf("t3_ready_k%0d", k), 64'(in_ready), 64'(k < 4));
      chk($sformatf("t3_done_k%0d", k), 64'(done), 64'(k >= 7));
    end
    in_valid = 1'b0;
    chk("t3_sample_cnt", 64'(sample_cnt), 64'd4);
    chk("t3_err_cnt", 64'(err_cnt), 64'd4);
    chk("t3_sum_ed", 64'(sum_ed), 64'd8);
    chk("t3_max_ed", 64'(max_ed), 64'd2);
`ifdef ADDER_ERR_MON_SQ_EN
    chk("t3_sum_sq_ed", 64'(sum_sq_ed), 64'd16);
`endif

    // Reset mid-campaign
    pulse_start();
    send(9'd0, 9'd8);
    send(9'd0, 9'd8);
    tick(); tick();
    chk("t4_sample_pre", 64'(sample_cnt), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_sample_rst", 64'(sample_cnt), 64'd0);
    chk("t4_err_rst", 64'(err_cnt), 64'd0);
    chk("t4_sum_ed_rst", 64'(sum_ed), 64'd0);
    chk("t4_max_ed_rst", 64'(max_ed), 64'd0);
    chk("t4_busy_rst", 64'(busy), 64'd0);
    chk("t4_ready_rst", 64'(in_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("t4_ready_idle", 64'(in_ready), 64'd0);
    chk("t4_busy_idle", 64'(busy), 64'd0);
    chk("t4_done_idle", 64'(done), 64'd0);
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("t4_no_xfer_idle", 64'(sample_cnt), 64'd0);

    // Gapped valid, equal pairs, N_SAMPLES=3
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      in_valid3 = (k % 3 == 0);
      s3 = W'(40 + 7 * k);
      tick();
    end
    in_valid3 = 1'b0;
    chk("t5_done", 64'(done3), 64'd1);
    chk("t5_sample_cnt", 64'(sample_cnt3), 64'd3);
    chk("t5_err_cnt", 64'(err_cnt3), 64'd0);
    chk("t5_sum_ed", 64'(sum_ed3), 64'd0);
    chk("t5_max_ed", 64'(max_ed3), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
